spike_burst_writer: RTL and testbench

//  Write-side counterpart of the spiking encoder's burst-read path. Packs per-pixel TIME_STEPS-bit spike

---
 rtl/spike_burst_writer_pkg.sv | 12 +
 rtl/spike_wr_bank.sv | 27 ++
 rtl/spike_burst_writer.sv | 170 +++++++++++++++++
 tb/tb_spike_burst_writer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_burst_writer_pkg.sv
// Shared types for the spike-map burst writer: write-side FSM state encoding.
package spike_burst_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_DATA,
    ST_WAIT_FIN,
    ST_DONE
  } wr_state_t;

endpackage

// File: rtl/spike_wr_bank.sv
// Ping-pong word buffer: simple dual-port RAM, two banks of BURST_LEN words, registered read.
module spike_wr_bank #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BURST_LEN  = 64,
  parameter int unsigned AW         = $clog2(2 * BURST_LEN)
) (
  input  logic                  s_clk,
  input  logic                  s_rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2*BURST_LEN];

  always_ff @(posedge s_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/spike_burst_writer.sv
// Packs TIME_STEPS-bit spike vectors into DDR words, buffers them in two banks
// and burst-writes each bank through one arbiter write port.
module spike_burst_writer
  import spike_burst_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned TIME_STEPS = 4,
  parameter int unsigned ADDR_SIZE  = 32,
  parameter int unsigned LEN_WIDTH  = 10,
  parameter int unsigned BURST_LEN  = 64,
  parameter int unsigned ADDR_STEP  = 8
) (
  input  logic                  s_clk,
  input  logic                  s_rst,
  input  logic                  i_start,
  input  logic [ADDR_SIZE-1:0]  i_base_addr,
  input  logic [TIME_STEPS-1:0] i_spike,
  input  logic                  i_spike_valid,
  input  logic                  i_spike_done,
  output logic [DATA_WIDTH-1:0] burst_write_data,
  output logic [ADDR_SIZE-1:0]  burst_write_addr,
  output logic [LEN_WIDTH-1:0]  burst_write_len,
  output logic                  burst_write_req,
  input  logic                  burst_write_valid,
  input  logic                  burst_write_finish,
  output logic                  o_write_done,
  output logic                  o_overflow
);

  localparam int unsigned PACK  = DATA_WIDTH / TIME_STEPS;
  localparam int unsigned CW    = $clog2(PACK);
  localparam int unsigned CNT_W = CW + 1;
  localparam int unsigned WW    = $clog2(BURST_LEN);
  localparam int unsigned AW    = WW + 1;
  localparam logic [ADDR_SIZE-1:0] BURST_BYTES = ADDR_SIZE'(BURST_LEN * ADDR_STEP);

  wr_state_t state, state_nxt;

  logic                  active, flush_pend, overflow_q;
  logic [CW-1:0]         vec_cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [DATA_WIDTH-1:0] pack_q, pack_nxt, word_q, rd_data;
  logic                  word_wr, fill_bank, rd_bank;
  logic [LEN_WIDTH-1:0]  wcnt, wcnt_nxt, rd_ptr, rd_ptr_nxt;
  logic [1:0]            bank_full;
  logic [LEN_WIDTH-1:0]  bank_len [2];
  logic [ADDR_SIZE-1:0]  base_q, burst_idx;
  logic                  vec_in, emit, wr_en, seal, in_burst, last_acc, burst_end, work_left;

  always_comb begin
    vec_in   = active & i_spike_valid;
    pack_nxt = pack_q;
    if (vec_in) pack_nxt[vec_cnt*TIME_STEPS +: TIME_STEPS] = i_spike;
    cnt_nxt  = {1'b0, vec_cnt} + CNT_W'(vec_in);
    // a flush closes a partial word immediately, including a vector arriving with it
    emit     = (cnt_nxt == CNT_W'(PACK)) | (active & i_spike_done & (cnt_nxt != '0));

    wr_en    = word_wr & ~bank_full[fill_bank];
    wcnt_nxt = wcnt + LEN_WIDTH'(wr_en);
    seal     = (wcnt_nxt == LEN_WIDTH'(BURST_LEN)) | (flush_pend & (wcnt_nxt != '0));

    in_burst   = (state == ST_REQ) | (state == ST_DATA);
    last_acc   = in_burst & burst_write_valid & (rd_ptr == bank_len[rd_bank] - LEN_WIDTH'(1));
    burst_end  = ((state == ST_WAIT_FIN) | last_acc) & burst_write_finish;
    rd_ptr_nxt = rd_ptr + LEN_WIDTH'(in_burst & burst_write_valid);
    work_left  = bank_full[~rd_bank] | (wcnt != '0) | word_wr;
  end

  always_ff @(posedge s_clk) begin
    if (s_rst || i_start) begin
      active      <= ~s_rst;
      base_q      <= s_rst ? '0 : i_base_addr;
      flush_pend  <= 1'b0;
      overflow_q  <= 1'b0;
      vec_cnt     <= '0;
      pack_q      <= '0;
      word_q      <= '0;
      word_wr     <= 1'b0;
      fill_bank   <= 1'b0;
      rd_bank     <= 1'b0;
      wcnt        <= '0;
      bank_full   <= '0;
      bank_len[0] <= '0;
      bank_len[1] <= '0;
      burst_idx   <= '0;
      rd_ptr      <= '0;
    end else begin
      pack_q  <= emit ? '0 : pack_nxt;
      vec_cnt <= emit ? '0 : cnt_nxt[CW-1:0];
      word_wr <= emit;
      if (emit) word_q <= pack_nxt;
      if (word_wr && bank_full[fill_bank]) overflow_q <= 1'b1;
      if (seal) begin
        bank_full[fill_bank] <= 1'b1;
        bank_len[fill_bank]  <= wcnt_nxt;
        fill_bank            <= ~fill_bank;
        wcnt                 <= '0;
      end else begin
        wcnt <= wcnt_nxt;
      end
      // banks fill and drain in the same alternating order, so rd_bank is always the oldest
      if (burst_end) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank            <= ~rd_bank;
        burst_idx          <= burst_idx + 1'b1;
        rd_ptr             <= '0;
      end else begin
        rd_ptr <= rd_ptr_nxt;
      end
      if (active && i_spike_done) flush_pend <= 1'b1;
      else if (state == ST_DONE)  flush_pend <= 1'b0;
    end
  end

  // read address looks one accept ahead so rd_data always holds the current word
  spike_wr_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .BURST_LEN  (BURST_LEN),
    .AW         (AW)
  ) u_bank (
    .s_clk   (s_clk),
    .s_rst   (s_rst),
    .wr_en   (wr_en),
    .wr_addr ({fill_bank, wcnt[WW-1:0]}),
    .wr_data (word_q),
    .rd_addr ({rd_bank, rd_ptr_nxt[WW-1:0]}),
    .rd_data (rd_data)
  );

  always_ff @(posedge s_clk) begin
    if (s_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_start) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bank_full[rd_bank])           state_nxt = ST_REQ;
          else if (flush_pend && !work_left) state_nxt = ST_DONE;
        end
        ST_REQ, ST_DATA, ST_WAIT_FIN: begin
          if (burst_end)                   state_nxt = (flush_pend && !work_left) ? ST_DONE : ST_IDLE;
          else if (last_acc)               state_nxt = ST_WAIT_FIN;
          else if (in_burst && burst_write_valid) state_nxt = ST_DATA;
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    burst_write_req  = (state == ST_REQ);
    o_write_done     = (state == ST_DONE);
    o_overflow       = overflow_q;
    burst_write_addr = '0;
    burst_write_len  = '0;
    burst_write_data = '0;
    if (in_burst) begin
      burst_write_addr = base_q + burst_idx * BURST_BYTES;
      burst_write_len  = bank_len[rd_bank];
      burst_write_data = rd_data;
    end
  end

endmodule

// File: tb/tb_spike_burst_writer.sv
// Directed bench for spike_burst_writer with a behavioural arbiter/DDR model.
module tb_spike_burst_writer;

  logic        s_clk = 1'b0;
  logic        s_rst, i_start, i_spike_valid, i_spike_done;
  logic [31:0] i_base_addr;
  logic [3:0]  i_spike;
  logic [63:0] burst_write_data;
  logic [31:0] burst_write_addr;
  logic [9:0]  burst_write_len;
  logic        burst_write_req, burst_write_valid, burst_write_finish;
  logic        o_write_done, o_overflow;

  spike_burst_writer #(
    .DATA_WIDTH (64),
    .TIME_STEPS (4),
    .ADDR_SIZE  (32),
    .LEN_WIDTH  (10),
    .BURST_LEN  (64),
    .ADDR_STEP  (8)
  ) dut (
    .s_clk              (s_clk),
    .s_rst              (s_rst),
    .i_start            (i_start),
    .i_base_addr        (i_base_addr),
    .i_spike            (i_spike),
    .i_spike_valid      (i_spike_valid),
    .i_spike_done       (i_spike_done),
    .burst_write_data   (burst_write_data),
    .burst_write_addr   (burst_write_addr),
    .burst_write_len    (burst_write_len),
    .burst_write_req    (burst_write_req),
    .burst_write_valid  (burst_write_valid),
    .burst_write_finish (burst_write_finish),
    .o_write_done       (o_write_done),
    .o_overflow         (o_overflow)
  );

  always #5 s_clk = ~s_clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0, fin_cyc = 0, done_cyc = 0, d_cyc = 0, done_cnt = 0, abort_cnt = 0;
  int arb_stall = 0, arb_abort_at = -1;
  bit arb_hold = 0, arb_fin_coinc = 0;
  logic [63:0] ddr [logic [31:0]];
  logic [31:0] b_addr [$];
  int          b_len  [$];

  always @(posedge s_clk) cyc <= cyc + 1;
  always @(negedge s_clk) if (o_write_done) begin done_cnt++; done_cyc = cyc; end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rd(input logic [31:0] a);
    if (ddr.exists(a)) return ddr[a];
    return 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  function automatic logic [3:0] spike_of(input int mode, input logic [3:0] val, input int k);
    case (mode)
      0:       return val;
      1:       return 4'(k);
      2:       return 4'(k / 16);
      default: return 4'(k / 1024 + 1);
    endcase
  endfunction

  // arbiter + DDR model: grants each request after arb_stall cycles, one word per cycle
  initial begin : arbiter
    logic [31:0] a;
    int l;
    bit ab;
    burst_write_valid = 1'b0;
    burst_write_finish = 1'b0;
    forever begin
      @(negedge s_clk);
      burst_write_valid = 1'b0;
      burst_write_finish = 1'b0;
      if (burst_write_req && !arb_hold) begin
        a = burst_write_addr;
        l = int'(burst_write_len);
        ab = 1'b0;
        for (int s = 0; s < arb_stall; s++) @(negedge s_clk);
        for (int i = 0; i < l; i++) begin
          if (i == arb_abort_at) begin ab = 1'b1; break; end
          if (i == 1) chk("req_drop", burst_write_req, 0);
          burst_write_valid = 1'b1;
          burst_write_finish = arb_fin_coinc && (i == l - 1);
          if (burst_write_finish) fin_cyc = cyc;
          ddr[a + 32'(i * 8)] = burst_write_data;
          @(negedge s_clk);
        end
        burst_write_valid = 1'b0;
        if (ab) begin
          abort_cnt++;
          while (burst_write_req) @(negedge s_clk);
        end else begin
          if (l == 1) chk("req_drop", burst_write_req, 0);
          burst_write_finish = !arb_fin_coinc;
          if (!arb_fin_coinc) fin_cyc = cyc;
          b_addr.push_back(a);
          b_len.push_back(l);
        end
      end
    end
  end

  task automatic start(input logic [31:0] base);
    @(negedge s_clk); i_start = 1'b1; i_base_addr = base;
    @(negedge s_clk); i_start = 1'b0;
  endtask

  task automatic send(input int n, input int mode, input logic [3:0] val, input bit done_last);
    for (int k = 0; k < n; k++) begin
      @(negedge s_clk);
      i_spike_valid = 1'b1;
      i_spike = spike_of(mode, val, k);
      i_spike_done = done_last && (k == n - 1);
      if (i_spike_done) d_cyc = cyc;
    end
    @(negedge s_clk);
    i_spike_valid = 1'b0; i_spike_done = 1'b0; i_spike = '0;
  endtask

  task automatic do_done();
    @(negedge s_clk); i_spike_done = 1'b1; d_cyc = cyc;
    @(negedge s_clk); i_spike_done = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit);
    int t = 0;
    while (done_cnt <= base && t < limit) begin @(negedge s_clk); t++; end
    chk("done_seen", 64'(done_cnt > base), 1);
  endtask

  task automatic wait_bursts(input int n, input int limit);
    int t = 0;
    while (b_addr.size() < n && t < limit) begin @(negedge s_clk); t++; end
    chk("burst_count", b_addr.size(), n);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"},  burst_write_req, 0);
    chk({tag, "_addr"}, burst_write_addr, 0);
    chk({tag, "_len"},  burst_write_len, 0);
    chk({tag, "_data"}, burst_write_data, 0);
    chk({tag, "_done"}, o_write_done, 0);
    chk({tag, "_ovf"},  o_overflow, 0);
  endtask

  typedef struct {
    int          n;
    int          mode;
    logic [3:0]  val;
    bit          done_last;
    bit          fin_coinc;
    logic [9:0]  exp_len;
    logic [63:0] exp_w0;
    logic [63:0] exp_wl;
  } vec_t;

  vec_t tbl [6];

  initial begin : main
    int bb, dc, bad;
    logic [31:0] base;
    logic [3:0]  nb;

    tbl[0] = '{20, 0, 4'hF, 1'b0, 1'b0, 10'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_FFFF};
    tbl[1] = '{16, 0, 4'h5, 1'b1, 1'b1, 10'd1, 64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555};
    tbl[2] = '{ 1, 0, 4'h9, 1'b0, 1'b0, 10'd1, 64'h0000_0000_0000_0009, 64'h0000_0000_0000_0009};
    tbl[3] = '{17, 0, 4'h3, 1'b1, 1'b1, 10'd2, 64'h3333_3333_3333_3333, 64'h0000_0000_0000_0003};
    tbl[4] = '{33, 0, 4'hC, 1'b1, 1'b0, 10'd3, 64'hCCCC_CCCC_CCCC_CCCC, 64'h0000_0000_0000_000C};
    tbl[5] = '{24, 1, 4'h0, 1'b0, 1'b1, 10'd2, 64'hFEDC_BA98_7654_3210, 64'h0000_0000_7654_3210};

    s_rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_spike = '0;
    i_spike_valid = 1'b0; i_spike_done = 1'b0;
    repeat (3) @(negedge s_clk);
    chk_idle_outputs("reset");
    s_rst = 1'b0;

    // vectors and flush before any i_start are ignored
    send(16, 0, 4'h7, 1'b1);
    repeat (20) @(negedge s_clk);
    chk("prestart_bursts", b_addr.size(), 0);
    chk("prestart_done", done_cnt, 0);

    // empty map: done two cycles after the flush request, no burst
    start(32'h5000);
    dc = done_cnt;
    do_done();
    wait_done(dc, 20);
    chk("empty_done_lat", done_cyc - d_cyc, 2);
    repeat (3) @(negedge s_clk);
    chk("empty_bursts", b_addr.size(), 0);
    chk("empty_done_once", done_cnt, dc + 1);

    for (int e = 0; e < 6; e++) begin
      base = 32'h0001_0000 + 32'(e) * 32'h1000;
      arb_fin_coinc = tbl[e].fin_coinc;
      bb = b_addr.size();
      dc = done_cnt;
      start(base);
      send(tbl[e].n, tbl[e].mode, tbl[e].val, tbl[e].done_last);
      if (!tbl[e].done_last) do_done();
      wait_done(dc, 500);
      repeat (3) @(negedge s_clk);
      chk($sformatf("t%0d_bursts", e), b_addr.size(), bb + 1);
      chk($sformatf("t%0d_addr", e), b_addr[bb], base);
      chk($sformatf("t%0d_len", e), 64'(b_len[bb]), 64'(tbl[e].exp_len));
      chk($sformatf("t%0d_w0", e), rd(base), tbl[e].exp_w0);
      chk($sformatf("t%0d_wlast", e), rd(base + 32'(tbl[e].exp_len - 1) * 32'd8), tbl[e].exp_wl);
      chk($sformatf("t%0d_done_lat", e), done_cyc - fin_cyc, 1);
      chk($sformatf("t%0d_done_once", e), done_cnt, dc + 1);
    end
    arb_fin_coinc = 1'b0;

    // one full bank
    bb = b_addr.size();
    start(32'h1000);
    send(1024, 0, 4'hA, 1'b0);
    wait_bursts(bb + 1, 500);
    chk("full_addr", b_addr[bb], 32'h1000);
    chk("full_len", b_len[bb], 64);
    bad = 0;
    for (int j = 0; j < 64; j++)
      if (rd(32'h1000 + 32'(j * 8)) !== 64'hAAAA_AAAA_AAAA_AAAA) bad++;
    chk("full_words_bad", bad, 0);
    dc = done_cnt;
    do_done();
    wait_done(dc, 20);
    chk("full_done_lat", done_cyc - d_cyc, 2);

    // ping-pong with a slow arbiter
    arb_stall = 200;
    bb = b_addr.size();
    start(32'h1000);
    send(2048, 2, 4'h0, 1'b0);
    wait_bursts(bb + 2, 1000);
    chk("pp_addr0", b_addr[bb], 32'h1000);
    chk("pp_addr1", b_addr[bb + 1], 32'h1200);
    chk("pp_len1", b_len[bb + 1], 64);
    chk("pp_ovf", o_overflow, 0);
    bad = 0;
    for (int j = 0; j < 128; j++) begin
      nb = 4'(j);
      if (rd(32'h1000 + 32'(j * 8)) !== {16{nb}}) bad++;
    end
    chk("pp_words_bad", bad, 0);
    arb_stall = 0;
    dc = done_cnt;
    do_done();
    wait_done(dc, 20);

    // overflow: third bank dropped while the arbiter withholds grants
    arb_hold = 1'b1;
    bb = b_addr.size();
    start(32'h8000);
    send(3072, 3, 4'h0, 1'b0);
    chk("ovf_flag", o_overflow, 1);
    chk("ovf_req_held", burst_write_req, 1);
    chk("ovf_len", burst_write_len, 64);
    arb_hold = 1'b0;
    wait_bursts(bb + 2, 600);
    repeat (20) @(negedge s_clk);
    chk("ovf_bursts", b_addr.size(), bb + 2);
    chk("ovf_addr0", b_addr[bb], 32'h8000);
    chk("ovf_addr1", b_addr[bb + 1], 32'h8200);
    bad = 0;
    for (int j = 0; j < 64; j++) begin
      if (rd(32'h8000 + 32'(j * 8)) !== 64'h1111_1111_1111_1111) bad++;
      if (rd(32'h8200 + 32'(j * 8)) !== 64'h2222_2222_2222_2222) bad++;
    end
    chk("ovf_words_bad", bad, 0);
    chk("ovf_bank2_absent", 64'(ddr.exists(32'h8400)), 0);
    start(32'h9000);
    chk("ovf_cleared", o_overflow, 0);

    // reset in the middle of a data phase, then a clean run
    arb_abort_at = 30;
    dc = abort_cnt;
    start(32'h2000);
    send(1024, 0, 4'h6, 1'b0);
    for (int t = 0; t < 200 && abort_cnt == dc; t++) @(negedge s_clk);
    chk("rst_abort_seen", 64'(abort_cnt > dc), 1);
    s_rst = 1'b1;
    @(negedge s_clk);
    chk_idle_outputs("midrst");
    s_rst = 1'b0;
    arb_abort_at = -1;
    bb = b_addr.size();
    dc = done_cnt;
    start(32'h3000);
    send(16, 1, 4'h0, 1'b1);
    wait_done(dc, 200);
    chk("rst_bursts", b_addr.size(), bb + 1);
    chk("rst_addr", b_addr[bb], 32'h3000);
    chk("rst_len", b_len[bb], 1);
    chk("rst_word", rd(32'h3000), 64'hFEDC_BA98_7654_3210);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "timeout");
  end

endmodule
